jury_vote_collector: RTL
========================

// Module: jury_vote_collector
// PURPOSE
// - Successor to the 2-bit single-juror input stage. Collects one 2-bit vote per juror for N_JURORS jurors during a timed session.
// - Locks each juror's first vote and tallies approve/reject/abstain counts.
// - Issues a registered verdict with a one-cycle done pulse.
// - Sits between the juror input pads (already synchronised) and the scoring/display logic.
// PARAMETERS
// - N_JURORS     4     number of juror channels, >=1
// - TIMEOUT_CYC  1000  max COLLECT cycles before forced decision, >=1
// - CNT_W        $clog2(N_JURORS+1)  tally width (localparam, derived)
// PORTS
// - clk          in   1            single clock, all state on rising edge
// - rst          in   1            synchronous, active-high reset
// - start        in   1            opens a session; sampled only in IDLE
// - J            in   2*N_JURORS   juror i vote = J[2i+1:2i]: 00 none, 01 reject, 10 approve, 11 abstain
// - busy         out  1            high in COLLECT and DECIDE
// - locked       out  N_JURORS     bit i set once juror i's vote is captured
// - done         out  1            one-cycle pulse when the verdict becomes valid
// - verdict      out  1            1 = approved; held until next start
// - tie          out  1            approve_cnt == reject_cnt at decision
// - timed_out    out  1            session ended by timeout, not by all jurors locked
// - approve_cnt  out  CNT_W        approve tally
// - reject_cnt   out  CNT_W        reject tally
// - abstain_cnt  out  CNT_W        abstain tally (incl. jurors missing at timeout)
// BEHAVIOUR
// - Reset: state=IDLE; every output 0; timer 0. Reset mid-session aborts it; no done pulse.
// - FSM states: IDLE -> COLLECT -> DECIDE -> IDLE.
// - IDLE, start=1:
//   - next cycle COLLECT, busy=1.
//   - locked, counts, verdict, tie and timed_out clear to 0; timer clears to 0.
//   - J is not sampled in the start cycle.
// - COLLECT:
//   - Each cycle, every unlocked juror with J!=00 gets locked[i]<=1 and its count +1.
//   - Several jurors may lock in the same cycle; all are counted.
//   - Votes from a juror that is already locked are ignored, even if changed.
//   - The timer increments each cycle.
// - COLLECT exit to DECIDE, on the first cycle where either holds:
//   - (locked | newly_locked) is all ones;
//   - timer == TIMEOUT_CYC-1. Set timed_out=1 only if not all jurors are locked.
//   - If both hold in the same cycle, all-locked wins: timed_out=0.
// - DECIDE, one cycle:
//   - abstain_cnt += popcount(~locked); set locked to all ones.
//   - verdict = approve_cnt > reject_cnt; tie = (approve_cnt == reject_cnt).
//   - Next state IDLE; done=1 in that first IDLE cycle only.
// - Latency: last vote seen in cycle t -> DECIDE at t+1 -> done/verdict valid at t+2.
// - start in the same cycle as done is accepted. start while busy is ignored.
// - Counts never overflow: each count is bounded by N_JURORS.
// CONFIGURATION
// - JURY_TIEBREAK_EN defined:
//   - On a tie with juror 0 voting approve, verdict=1; otherwise verdict=0.
//   - tie is still reported.
// - JURY_TIEBREAK_EN undefined: a tie always gives verdict=0.
// TESTING
// - N=4, after start J=10_10_01_10 in one cycle -> DECIDE next cycle; done 2 cycles after vote; approve=3, reject=1, verdict=1, tie=0, timed_out=0.
// - Juror 2 votes 01, then changes to 10 -> stays counted reject; locked[2]=1 from first vote.
// - TIMEOUT_CYC=8, only juror 0 votes 10 -> done after timeout; abstain=3, approve=1, verdict=1, timed_out=1, locked=4'hF.
// - Tie 2-2 with juror0=10 -> verdict=1 with JURY_TIEBREAK_EN, verdict=0 without; tie=1 in both.
// - rst pulsed mid-COLLECT -> next cycle all outputs 0, state IDLE, no done; a fresh start works normally.
// - start held high continuously -> back-to-back sessions; done pulse coincides with the next session's start acceptance.

Source files
------------

// File: rtl/jury_vote_collector.sv
// Collects one locked 2-bit vote per juror during a timed session, tallies it and
// registers a verdict with a one-cycle done pulse. Optional macro: JURY_TIEBREAK_EN.
module jury_vote_collector #(
    parameter int N_JURORS    = 4,
    parameter int TIMEOUT_CYC = 1000,
    localparam int CNT_W      = $clog2(N_JURORS + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*N_JURORS-1:0] J,
    output logic                  busy,
    output logic [N_JURORS-1:0]   locked,
    output logic                  done,
    output logic                  verdict,
    output logic                  tie,
    output logic                  timed_out,
    output logic [CNT_W-1:0]      approve_cnt,
    output logic [CNT_W-1:0]      reject_cnt,
    output logic [CNT_W-1:0]      abstain_cnt
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE
    } state_t;

    state_t                r_state;
    logic [TW-1:0]         r_timer;
    logic                  r_busy;
    logic [N_JURORS-1:0]   r_locked;
    logic                  r_done;
    logic                  r_verdict;
    logic                  r_tie;
    logic                  r_timed_out;
    logic [CNT_W-1:0]      r_approve;
    logic [CNT_W-1:0]      r_reject;
    logic [CNT_W-1:0]      r_abstain;
`ifdef JURY_TIEBREAK_EN
    logic                  r_j0_approve;
`endif

    logic [N_JURORS-1:0]   w_new;
    logic [CNT_W-1:0]      w_add_app;
    logic [CNT_W-1:0]      w_add_rej;
    logic [CNT_W-1:0]      w_add_abs;
    logic [CNT_W-1:0]      w_missing;
    logic                  w_all_locked;
    logic                  w_timeout;

    always_comb begin
        w_new     = '0;
        w_add_app = '0;
        w_add_rej = '0;
        w_add_abs = '0;
        w_missing = '0;
        for (int unsigned i = 0; i < N_JURORS; i++) begin
            if (!r_locked[i]) begin
                w_missing = w_missing + CNT_W'(1);
                if (J[2*i +: 2] != 2'b00) begin
                    w_new[i] = 1'b1;
                    case (J[2*i +: 2])
                        2'b01:   w_add_rej = w_add_rej + CNT_W'(1);
                        2'b10:   w_add_app = w_add_app + CNT_W'(1);
                        default: w_add_abs = w_add_abs + CNT_W'(1);
                    endcase
                end
            end
        end
        w_all_locked = &(r_locked | w_new);
        w_timeout    = (r_timer == TW'(TIMEOUT_CYC - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_busy      <= 1'b0;
            r_locked    <= '0;
            r_done      <= 1'b0;
            r_verdict   <= 1'b0;
            r_tie       <= 1'b0;
            r_timed_out <= 1'b0;
            r_approve   <= '0;
            r_reject    <= '0;
            r_abstain   <= '0;
`ifdef JURY_TIEBREAK_EN
            r_j0_approve <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_COLLECT;
                        r_busy      <= 1'b1;
                        r_timer     <= '0;
                        r_locked    <= '0;
                        r_verdict   <= 1'b0;
                        r_tie       <= 1'b0;
                        r_timed_out <= 1'b0;
                        r_approve   <= '0;
                        r_reject    <= '0;
                        r_abstain   <= '0;
`ifdef JURY_TIEBREAK_EN
                        r_j0_approve <= 1'b0;
`endif
                    end
                end
                S_COLLECT: begin
                    r_locked  <= r_locked | w_new;
                    r_approve <= r_approve + w_add_app;
                    r_reject  <= r_reject + w_add_rej;
                    r_abstain <= r_abstain + w_add_abs;
                    r_timer   <= r_timer + TW'(1);
`ifdef JURY_TIEBREAK_EN
                    if (w_new[0] && J[1:0] == 2'b10)
                        r_j0_approve <= 1'b1;
`endif
                    // all-locked takes priority over a coincident timeout
                    if (w_all_locked) begin
                        r_state <= S_DECIDE;
                    end else if (w_timeout) begin
                        r_state     <= S_DECIDE;
                        r_timed_out <= 1'b1;
                    end
                end
                S_DECIDE: begin
                    r_abstain <= r_abstain + w_missing;
                    r_locked  <= '1;
                    r_tie     <= (r_approve == r_reject);
`ifdef JURY_TIEBREAK_EN
                    r_verdict <= (r_approve > r_reject) ||
                                 ((r_approve == r_reject) && r_j0_approve);
`else
                    r_verdict <= (r_approve > r_reject);
`endif
                    r_busy    <= 1'b0;
                    r_done    <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign locked      = r_locked;
    assign done        = r_done;
    assign verdict     = r_verdict;
    assign tie         = r_tie;
    assign timed_out   = r_timed_out;
    assign approve_cnt = r_approve;
    assign reject_cnt  = r_reject;
    assign abstain_cnt = r_abstain;

endmodule
